// File: rtl/user_io_bridge.sv
// Memory-mapped user I/O bridge: buffers user input words in a small FIFO for CPU reads
// and forwards CPU-written words to the user side over a valid/ready handshake.
module user_io_bridge #(
  parameter int DEPTH = 4,
  parameter int IN_W  = 6,
  parameter int DW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      cpu_addr,
  input  logic            cpu_rd,
  input  logic            cpu_wr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [DW-1:0]   cpu_rdata,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_TXDATA = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  typedef enum logic {IDLE, SEND} tx_state_t;

  logic [IN_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            ovf, drop;
  tx_state_t       tx_state;

  logic            full, nonempty, rd_en, pop, push, flush, clr_flags, tx_wr, tx_busy;
  logic [2:0]      count_field;
  logic [DW-1:0]   status_word, head_word;

  // A read strobe coinciding with a write is ignored entirely, so it can never pop.
  always_comb begin
    full        = (count == CW'(DEPTH));
    nonempty    = (count != '0);
    tx_busy     = (tx_state == SEND);
    rd_en       = cpu_rd && !cpu_wr;
    pop         = rd_en && (cpu_addr == ADDR_RXDATA) && nonempty;
    push        = in_valid && (!full || pop);
    flush       = cpu_wr && (cpu_addr == ADDR_CTRL) && cpu_wdata[1];
    clr_flags   = cpu_wr && (cpu_addr == ADDR_CTRL) && cpu_wdata[0];
    tx_wr       = cpu_wr && (cpu_addr == ADDR_TXDATA);
    count_field = (32'(count) > 7) ? 3'd7 : 3'(count);
    status_word = {{(DW-7){1'b0}}, drop, ovf, count_field, tx_busy, nonempty};
    head_word   = {{(DW-IN_W){1'b0}}, mem[rptr]};
  end

  assign in_ready = !full;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= in_data;
  end

  // Flush has priority over any push or pop landing on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Overflow only flags words that were actually discarded; setting wins over clearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf  <= 1'b0;
      drop <= 1'b0;
    end else begin
      if (clr_flags) begin
        ovf  <= 1'b0;
        drop <= 1'b0;
      end
      if (in_valid && full && !pop) ovf  <= 1'b1;
      if (tx_wr && tx_busy)         drop <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata <= '0;
    end else if (rd_en) begin
      case (cpu_addr)
        ADDR_STATUS: cpu_rdata <= status_word;
        ADDR_RXDATA: cpu_rdata <= nonempty ? head_word : '0;
        default:     cpu_rdata <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state  <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (tx_state)
        IDLE: if (tx_wr) begin
          out_data  <= cpu_wdata;
          out_valid <= 1'b1;
          tx_state  <= SEND;
        end
        SEND: if (out_ready) begin
          out_valid <= 1'b0;
          tx_state  <= IDLE;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_io_bridge.sv
// Directed self-checking bench for user_io_bridge: FIFO push/pop, overflow, flush,
// TX handshake with drop, read/write collision and mid-operation reset.
module tb_user_io_bridge;

  logic        clk;
  logic        rst;
  logic [1:0]  cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        in_valid;
  logic [5:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  user_io_bridge #(.DEPTH(4), .IN_W(6), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and outputs are sampled at the same point.
  task automatic apply_stimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_read(input logic [1:0] addr);
    cpu_addr = addr;
    cpu_rd   = 1'b1;
    apply_stimulus(1);
    cpu_rd   = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [15:0] data);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_wr    = 1'b1;
    apply_stimulus(1);
    cpu_wr    = 1'b0;
  endtask

  task automatic push_word(input logic [5:0] data);
    in_valid = 1'b1;
    in_data  = data;
    apply_stimulus(1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    cpu_addr  = 2'd0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_wdata = 16'h0000;
    in_valid  = 1'b0;
    in_data   = 6'd0;
    out_ready = 1'b0;

    $display("[TB] reset and idle status");
    apply_stimulus(3);
    check_output("reset_rdata", cpu_rdata, 32'h0);
    check_output("reset_in_ready", in_ready, 32'h1);
    check_output("reset_out_valid", out_valid, 32'h0);
    check_output("reset_out_data", out_data, 32'h0);
    rst = 1'b1;
    apply_stimulus(1);
    cpu_read(2'd0);
    check_output("reset_status", cpu_rdata, 32'h0000);

    $display("[TB] two-word push and pop");
    push_word(6'd28);
    push_word(6'd5);
    cpu_read(2'd0);
    check_output("two_status", cpu_rdata, 32'h0009);
    cpu_read(2'd1);
    check_output("two_pop0", cpu_rdata, 32'h001C);
    cpu_read(2'd1);
    check_output("two_pop1", cpu_rdata, 32'h0005);
    cpu_read(2'd0);
    check_output("two_status_empty", cpu_rdata, 32'h0000);
    cpu_read(2'd1);
    check_output("empty_rx_read", cpu_rdata, 32'h0000);
    cpu_read(2'd0);
    check_output("empty_rx_no_flag", cpu_rdata, 32'h0000);

    $display("[TB] fill and overflow");
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 6'(10 + i);
      apply_stimulus(1);
      if (i == 3) check_output("full_in_ready", in_ready, 32'h0);
    end
    in_valid = 1'b0;
    cpu_read(2'd0);
    check_output("ovf_status", cpu_rdata, 32'h0031);
    for (int i = 0; i < 4; i++) begin
      cpu_read(2'd1);
      check_output($sformatf("ovf_pop%0d", i), cpu_rdata, 32'(10 + i));
    end
    check_output("drained_in_ready", in_ready, 32'h1);
    cpu_write(2'd3, 16'h0001);
    cpu_read(2'd0);
    check_output("ovf_cleared", cpu_rdata, 32'h0000);

    $display("[TB] push and pop on a full fifo");
    for (int i = 0; i < 4; i++) push_word(6'(20 + i));
    cpu_read(2'd0);
    check_output("full_status", cpu_rdata, 32'h0011);
    in_valid = 1'b1;
    in_data  = 6'd24;
    cpu_addr = 2'd1;
    cpu_rd   = 1'b1;
    apply_stimulus(1);
    cpu_rd   = 1'b0;
    in_valid = 1'b0;
    check_output("full_pushpop_data", cpu_rdata, 32'd20);
    cpu_read(2'd0);
    check_output("full_pushpop_status", cpu_rdata, 32'h0011);
    for (int i = 0; i < 4; i++) begin
      cpu_read(2'd1);
      check_output($sformatf("wrap_pop%0d", i), cpu_rdata, 32'(21 + i));
    end

    $display("[TB] flush beats a same-cycle push");
    push_word(6'd1);
    push_word(6'd2);
    in_valid = 1'b1;
    in_data  = 6'd30;
    cpu_write(2'd3, 16'h0002);
    in_valid = 1'b0;
    cpu_read(2'd0);
    check_output("flush_status", cpu_rdata, 32'h0000);

    $display("[TB] tx handshake and drop");
    cpu_write(2'd2, 16'hBEEF);
    check_output("tx_valid", out_valid, 32'h1);
    check_output("tx_data", out_data, 32'hBEEF);
    apply_stimulus(2);
    check_output("tx_valid_held", out_valid, 32'h1);
    cpu_read(2'd0);
    check_output("tx_busy_status", cpu_rdata, 32'h0002);
    cpu_write(2'd2, 16'h1234);
    check_output("tx_data_kept", out_data, 32'hBEEF);
    cpu_read(2'd0);
    check_output("drop_status", cpu_rdata, 32'h0042);
    out_ready = 1'b1;
    apply_stimulus(1);
    out_ready = 1'b0;
    check_output("tx_done_valid", out_valid, 32'h0);
    cpu_read(2'd0);
    check_output("tx_done_status", cpu_rdata, 32'h0040);
    cpu_read(2'd2);
    check_output("txdata_reads_zero", cpu_rdata, 32'h0000);
    cpu_read(2'd0);
    check_output("drop_before_collision", cpu_rdata, 32'h0040);
    cpu_addr  = 2'd3;
    cpu_wdata = 16'h0001;
    cpu_rd    = 1'b1;
    cpu_wr    = 1'b1;
    apply_stimulus(1);
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    check_output("rdwr_rdata_holds", cpu_rdata, 32'h0040);
    cpu_read(2'd0);
    check_output("rdwr_write_done", cpu_rdata, 32'h0000);

    $display("[TB] reset in the middle of a transfer");
    cpu_write(2'd2, 16'hCAFE);
    for (int i = 0; i < 3; i++) push_word(6'(1 + i));
    cpu_read(2'd0);
    check_output("pre_reset_status", cpu_rdata, 32'h000F);
    #2 rst = 1'b0;
    #1;
    check_output("midrst_out_valid", out_valid, 32'h0);
    check_output("midrst_rdata", cpu_rdata, 32'h0);
    check_output("midrst_in_ready", in_ready, 32'h1);
    apply_stimulus(2);
    rst = 1'b1;
    apply_stimulus(1);
    cpu_read(2'd0);
    check_output("post_reset_status", cpu_rdata, 32'h0000);
    push_word(6'd7);
    cpu_read(2'd1);
    check_output("post_reset_pop", cpu_rdata, 32'h0007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
